// File: rtl/cap_mem_ctrl_if.sv
// Request/response bus of the capability memory controller.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface cap_mem_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic         req_cap;
  logic [31:0]  req_addr;
  logic [128:0] req_wdata;
  logic         comp_en;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [128:0] rsp_rdata;
  logic         rsp_err;

  modport master (
    output req_valid, req_we, req_cap, req_addr, req_wdata, comp_en, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_cap, req_addr, req_wdata, comp_en, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/cap_mem_ctrl.sv
// Single-outstanding controller for a tagged 129-bit capability memory.
// Each access waits a fixed number of cycles, then answers once on the response channel.
module cap_mem_ctrl #(
  parameter int DEPTH     = 256,
  parameter int WAIT_BASE = 4,
  parameter int WAIT_COMP = 3
) (
  input  logic          clk,
  input  logic          rst,
  cap_mem_ctrl_if.slave bus,
  output logic          busy,
  output logic [31:0]   stat_loads,
  output logic [31:0]   stat_stores,
  output logic [31:0]   stat_wait,
  output logic [1:0]    state_dbg_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q;
  logic           we_q;
  logic           cap_q;
  logic [AW-1:0]  idx_q;
  logic [128:0]   wdata_q;
  logic [128:0]   rdata_q;
  logic           err_q;
  logic [31:0]    loads_q, stores_q, wait_q;
  logic [DEPTH-1:0] tag_q;
  logic [127:0]   data_mem [DEPTH];

  logic addr_err;
  logic accept;
  logic wait_done;

  assign addr_err  = (bus.req_addr[3:0] != 4'd0) || (bus.req_addr[31:AW+4] != '0);
  assign accept    = (state_q == S_IDLE) && bus.req_valid;
  assign wait_done = (state_q == S_WAIT) && (cnt_q == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) state_d = addr_err ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tags live in resettable flops; data bits sit in a plain array that survives reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      cap_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      loads_q  <= 32'd0;
      stores_q <= 32'd0;
      wait_q   <= 32'd0;
      tag_q    <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        cap_q   <= bus.req_cap;
        idx_q   <= bus.req_addr[AW+3:4];
        wdata_q <= bus.req_wdata;
        err_q   <= addr_err;
        rdata_q <= '0;
        cnt_q   <= bus.comp_en ? 4'(WAIT_COMP) : 4'(WAIT_BASE);
      end
      if (state_q == S_WAIT) begin
        cnt_q  <= cnt_q - 4'd1;
        wait_q <= (wait_q == 32'hFFFF_FFFF) ? wait_q : wait_q + 32'd1;
      end
      if (wait_done) begin
        if (we_q) begin
          tag_q[idx_q] <= cap_q & wdata_q[128];
          rdata_q      <= '0;
          stores_q     <= (stores_q == 32'hFFFF_FFFF) ? stores_q : stores_q + 32'd1;
        end else begin
          rdata_q <= {tag_q[idx_q], data_mem[idx_q]};
          loads_q <= (loads_q == 32'hFFFF_FFFF) ? loads_q : loads_q + 32'd1;
        end
      end
      if ((state_q == S_RESP) && bus.rsp_ready) err_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wait_done && we_q) data_mem[idx_q] <= wdata_q[127:0];
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != S_IDLE);
  assign stat_loads    = loads_q;
  assign stat_stores   = stores_q;
  assign stat_wait     = wait_q;
  assign state_dbg_o   = state_q;
endmodule

// File: tb/tb_cap_mem_ctrl.sv
// Directed bench for cap_mem_ctrl: the driver pushes expected responses, a monitor pops and compares.
module tb_cap_mem_ctrl;
  localparam int W = 138;  // {latency[7:0], err, rdata[128:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [31:0] stat_loads, stat_stores, stat_wait;
  logic [1:0]  state_dbg;

  cap_mem_ctrl_if bus_if();

  cap_mem_ctrl #(.DEPTH(256), .WAIT_BASE(4), .WAIT_COMP(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .busy        (busy),
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_wait   (stat_wait),
    .state_dbg_o (state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  int acc_cyc = 0;

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Driver
  task automatic issue(input logic we, input logic cap, input logic [31:0] addr,
                       input logic [128:0] wd, input logic comp, input logic expect_rsp,
                       input logic [128:0] erd, input logic eerr, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = we;
    bus_if.req_cap   = cap;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wd;
    bus_if.comp_en   = comp;
    while (!bus_if.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 129'(bus_if.req_ready), 129'(1));
    acc_cyc = cyc;
    if (expect_rsp) exp_q.push_back({8'(lat), eerr, erd});
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    bus_if.comp_en   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 129'(busy), 129'(0));
    check("queue_drained", 129'(exp_q.size()), 129'(0));
  endtask

  // Monitor / scoreboard
  logic         seen = 1'b0;
  logic [128:0] snap_rdata;
  logic         snap_err;
  logic [W-1:0] e;

  always @(negedge clk) begin
    if (!rst && bus_if.rsp_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 129'(1), 129'(0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", bus_if.rsp_rdata, e[128:0]);
          check("rsp_err", 129'(bus_if.rsp_err), 129'(e[129]));
          check("rsp_latency", 129'(cyc - acc_cyc), 129'(e[137:130]));
        end
        seen = 1'b1;
        snap_rdata = bus_if.rsp_rdata;
        snap_err = bus_if.rsp_err;
      end else begin
        check("rsp_rdata_stable", bus_if.rsp_rdata, snap_rdata);
        check("rsp_err_stable", 129'(bus_if.rsp_err), 129'(snap_err));
      end
    end else begin
      seen = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus_if.req_valid = 1'b0;
    bus_if.req_we    = 1'b0;
    bus_if.req_cap   = 1'b0;
    bus_if.req_addr  = 32'd0;
    bus_if.req_wdata = '0;
    bus_if.comp_en   = 1'b0;
    bus_if.rsp_ready = 1'b1;

    do_reset();
    check("rst_rsp_valid", 129'(bus_if.rsp_valid), 129'(0));
    check("rst_rsp_err", 129'(bus_if.rsp_err), 129'(0));
    check("rst_rsp_rdata", bus_if.rsp_rdata, 129'(0));
    check("rst_busy", 129'(busy), 129'(0));
    check("rst_req_ready", 129'(bus_if.req_ready), 129'(1));
    check("rst_stats", 129'({stat_loads, stat_stores, stat_wait}), 129'(0));

    // Capability store keeps tag, then load it back
    issue(1'b1, 1'b1, 32'h20, {1'b1, 128'hABCD}, 1'b0, 1'b1, 129'(0), 1'b0, 5);
    wait_idle();
    issue(1'b0, 1'b0, 32'h20, '0, 1'b0, 1'b1, {1'b1, 128'hABCD}, 1'b0, 5);
    wait_idle();
    check("stat_wait_2ops", 129'(stat_wait), 129'(8));
    check("stat_loads_1", 129'(stat_loads), 129'(1));
    check("stat_stores_1", 129'(stat_stores), 129'(1));

    // Data store clears tag
    issue(1'b1, 1'b0, 32'h30, {1'b1, 128'hABCD}, 1'b0, 1'b1, 129'(0), 1'b0, 5);
    wait_idle();
    issue(1'b0, 1'b0, 32'h30, '0, 1'b0, 1'b1, {1'b0, 128'hABCD}, 1'b0, 5);
    wait_idle();

    // Compressed wait count latched at accept, comp_en dropped afterwards
    issue(1'b0, 1'b0, 32'h20, '0, 1'b1, 1'b1, {1'b1, 128'hABCD}, 1'b0, 4);
    wait_idle();
    check("stat_wait_comp", 129'(stat_wait), 129'(19));

    // Misaligned and out-of-range addresses
    issue(1'b0, 1'b0, 32'h24, '0, 1'b0, 1'b1, 129'(0), 1'b1, 1);
    wait_idle();
    issue(1'b0, 1'b0, 32'h1000, '0, 1'b0, 1'b1, 129'(0), 1'b1, 1);
    wait_idle();
    issue(1'b1, 1'b1, 32'h08, {1'b1, 128'h5555}, 1'b0, 1'b1, 129'(0), 1'b1, 1);
    wait_idle();
    check("err_stat_wait", 129'(stat_wait), 129'(19));
    check("err_stat_loads", 129'(stat_loads), 129'(3));
    check("err_stat_stores", 129'(stat_stores), 129'(2));

    // Back-pressure on the response channel
    bus_if.rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 32'h20, '0, 1'b0, 1'b1, {1'b1, 128'hABCD}, 1'b0, 5);
    n = 0;
    while (!bus_if.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_rsp_valid", 129'(bus_if.rsp_valid), 129'(1));
    check("hold_req_ready_0", 129'(bus_if.req_ready), 129'(0));
    @(negedge clk);
    check("hold_req_ready_1", 129'(bus_if.req_ready), 129'(0));
    @(negedge clk);
    check("hold_req_ready_2", 129'(bus_if.req_ready), 129'(0));
    check("hold_rsp_valid_2", 129'(bus_if.rsp_valid), 129'(1));
    #1;
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    check("req_ready_after_hs", 129'(bus_if.req_ready), 129'(1));
    wait_idle();
    check("stat_wait_hold", 129'(stat_wait), 129'(23));

    // Reset clears tags but keeps data
    do_reset();
    check("rst2_stats", 129'({stat_loads, stat_stores, stat_wait}), 129'(0));
    issue(1'b0, 1'b0, 32'h20, '0, 1'b0, 1'b1, {1'b0, 128'hABCD}, 1'b0, 5);
    wait_idle();

    // Reset during WAIT of a store aborts the write
    issue(1'b1, 1'b1, 32'h40, {1'b1, 128'h1111}, 1'b0, 1'b1, 129'(0), 1'b0, 5);
    wait_idle();
    issue(1'b1, 1'b1, 32'h40, {1'b1, 128'h2222}, 1'b0, 1'b0, 129'(0), 1'b0, 0);
    check("abort_in_wait", 129'(state_dbg), 129'(1));
    do_reset();
    check("abort_busy", 129'(busy), 129'(0));
    issue(1'b0, 1'b0, 32'h40, '0, 1'b0, 1'b1, {1'b0, 128'h1111}, 1'b0, 5);
    wait_idle();
    check("final_stat_loads", 129'(stat_loads), 129'(1));
    check("final_stat_stores", 129'(stat_stores), 129'(0));
    check("final_stat_wait", 129'(stat_wait), 129'(4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
